// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with persistent status register and iterative multiply
//
// Purpose: accepts one operation per valid/ready transfer, computes single-cycle
// operations directly into a registered output holding stage, and runs MUL as a
// WIDTH-cycle unsigned shift-add. A persistent status register (psr) captures the
// flags of flag-producing operations at the moment the output stage loads.
//
// Parameters:
//   WIDTH  - operand/result width (>= 8, power of two)
//   IMM_W  - immediate field width, taken from b[IMM_W-1:0] (IMM_W <= WIDTH)
//   MUL_EN - 1 implements MUL; 0 makes opcode 0x0E decode as unknown
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operation presented
//   in_ready   out  operation can be accepted this cycle
//   opcode     in   8-bit operation code
//   a, b       in   source operands (b low bits double as immediate)
//   out_valid  out  result/flags held and valid
//   out_ready  in   consumer takes the result
//   result     out  registered result
//   flags      out  registered flags {C, L, F, Z, N}
//   psr        out  persistent status register, same layout as flags
//   busy       out  multiply in progress

module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic [4:0]       psr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    K_NONE,
    K_ADD,
    K_SUB,
    K_CMP,
    K_AND,
    K_OR,
    K_XOR,
    K_MOV,
    K_LUI,
    K_SHR,   // register shift, signed amount in b
    K_SHI,   // immediate shift, amount b[3:0], direction opcode[0]
    K_MUL
  } kind_t;

  state_t             state;
  kind_t              kind;
  logic               arith;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH-1:0]   imm_se;
  logic [WIDTH-1:0]   imm_ze;
  logic [WIDTH-1:0]   lui_val;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic               lt_s;

  logic               sh_right;
  logic [WIDTH-1:0]   sh_mag;
  logic [WIDTH-1:0]   sh_ars;
  logic [WIDTH-1:0]   sh_res;

  logic [WIDTH-1:0]   res_c;
  logic [4:0]         flg_c;
  logic               upd_c;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [4:0]         mul_flg;

  assign imm_se  = WIDTH'($signed(b[IMM_W-1:0]));
  assign imm_ze  = WIDTH'(b[IMM_W-1:0]);
  assign lui_val = WIDTH'(b[IMM_W-1:0]) << (WIDTH - IMM_W);

  // Exact opcodes first; the 0xNx families only apply when no exact match hits.
  always_comb begin
    kind  = K_NONE;
    bx    = b;
    arith = 1'b0;
    case (opcode)
      8'h05: kind = K_ADD;
      8'h09: kind = K_SUB;
      8'h0B: kind = K_CMP;
      8'h01: kind = K_AND;
      8'h02: kind = K_OR;
      8'h03: kind = K_XOR;
      8'h0D: kind = K_MOV;
      8'h84: kind = K_SHR;
      8'h86: begin kind = K_SHR; arith = 1'b1; end
      8'h80, 8'h81: kind = K_SHI;
      8'h82, 8'h83: begin kind = K_SHI; arith = 1'b1; end
      8'h0E: kind = (MUL_EN != 0) ? K_MUL : K_NONE;
      default: begin
        case (opcode[7:4])
          4'h5: begin kind = K_ADD; bx = imm_se; end
          4'h9: begin kind = K_SUB; bx = imm_se; end
          4'hB: begin kind = K_CMP; bx = imm_se; end
          4'h1: begin kind = K_AND; bx = imm_ze; end
          4'h2: begin kind = K_OR;  bx = imm_ze; end
          4'h3: begin kind = K_XOR; bx = imm_ze; end
          4'hD: begin kind = K_MOV; bx = imm_ze; end
          4'hF: kind = K_LUI;
          default: kind = K_NONE;
        endcase
      end
    endcase
  end

  // The borrow is the top bit of the widened difference; the signed less-than
  // is the difference sign corrected by overflow.
  assign sum     = {1'b0, a} + {1'b0, bx};
  assign diff    = {1'b0, a} - {1'b0, bx};
  assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != bx[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign lt_s    = diff[WIDTH-1] ^ sub_ovf;

  // Shifting by a full-width magnitude relies on the language rule that an
  // amount >= WIDTH yields zero (or sign fill for >>>), which covers the
  // out-of-range cases, including the most negative b.
  always_comb begin
    if (kind == K_SHI) begin
      sh_right = opcode[0];
      sh_mag   = WIDTH'(b[3:0]);
    end else begin
      sh_right = b[WIDTH-1];
      sh_mag   = b[WIDTH-1] ? -b : b;
    end
    sh_ars = $signed(a) >>> sh_mag;
    if (!sh_right) begin
      sh_res = a << sh_mag;
    end else if (arith) begin
      sh_res = sh_ars;
    end else begin
      sh_res = a >> sh_mag;
    end
  end

  always_comb begin
    res_c = '0;
    flg_c = '0;
    upd_c = 1'b0;
    case (kind)
      K_ADD: begin
        res_c = sum[WIDTH-1:0];
        flg_c = {sum[WIDTH], 1'b0, add_ovf, 2'b00};
        upd_c = 1'b1;
      end
      K_SUB, K_CMP: begin
        res_c = (kind == K_SUB) ? diff[WIDTH-1:0] : '0;
        flg_c = {diff[WIDTH], diff[WIDTH], sub_ovf, (a == bx), lt_s};
        upd_c = 1'b1;
      end
      K_AND: begin
        res_c = a & bx;
        flg_c = {3'b000, ~|(a & bx), 1'b0};
        upd_c = 1'b1;
      end
      K_OR:         res_c = a | bx;
      K_XOR:        res_c = a ^ bx;
      K_MOV:        res_c = bx;
      K_LUI:        res_c = lui_val;
      K_SHR, K_SHI: res_c = sh_res;
      default: begin
        res_c = '0;
        flg_c = '0;
        upd_c = 1'b0;
      end
    endcase
  end

  assign mul_flg  = {|acc[2*WIDTH-1:WIDTH], 2'b00, ~|acc[WIDTH-1:0], 1'b0};
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      flags     <= '0;
      psr       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      // A drain clears out_valid; any load below in the same cycle overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (kind == K_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              count  <= CW'(WIDTH - 1);
              busy   <= 1'b1;
              state  <= S_MUL_RUN;
            end else begin
              result    <= res_c;
              flags     <= flg_c;
              out_valid <= 1'b1;
              if (upd_c) begin
                psr <= flg_c;
              end
            end
          end
        end
        S_MUL_RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (count == '0) begin
            state <= S_DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        S_DONE: begin
          if (!out_valid || out_ready) begin
            result    <= acc[WIDTH-1:0];
            flags     <= mul_flg;
            psr       <= mul_flg;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural scoreboard

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;
  logic [4:0]  psr;
  logic        busy;

  logic        rand_ready = 1'b0;
  logic        ready_force = 1'b1;
  logic        rnd_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [4:0]  f;
    logic [4:0]  p;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] psr_m = 5'h00;

  alu_seq #(.WIDTH(16), .IMM_W(8), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .psr       (psr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  assign out_ready = rand_ready ? rnd_ready : ready_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  function automatic void model(input logic [7:0] op, input logic [15:0] va, input logic [15:0] vb,
                                output logic [15:0] r, output logic [4:0] f, output bit upd);
    int     ua, sa, bu, bs, kind, m, t;
    bit     right, arith, c, l, v, z, n;
    byte    imm;
    longint p;
    ua = va;
    sa = $signed(va);
    imm = vb[7:0];
    bu = vb;
    bs = $signed(vb);
    kind = 0;
    arith = 0;
    c = 0; l = 0; v = 0; z = 0; n = 0;
    r = 16'h0000;
    upd = 0;
    case (op)
      8'h05: kind = 1;
      8'h09: kind = 2;
      8'h0B: kind = 3;
      8'h01: kind = 4;
      8'h02: kind = 5;
      8'h03: kind = 6;
      8'h0D: kind = 7;
      8'h84: kind = 9;
      8'h86: begin kind = 9; arith = 1; end
      8'h80, 8'h81: kind = 10;
      8'h82, 8'h83: begin kind = 10; arith = 1; end
      8'h0E: kind = 11;
      default: begin
        case (op[7:4])
          4'h5: begin kind = 1; bs = imm; bu = int'(imm) & 32'hFFFF; end
          4'h9: begin kind = 2; bs = imm; bu = int'(imm) & 32'hFFFF; end
          4'hB: begin kind = 3; bs = imm; bu = int'(imm) & 32'hFFFF; end
          4'h1: begin kind = 4; bu = vb[7:0]; end
          4'h2: begin kind = 5; bu = vb[7:0]; end
          4'h3: begin kind = 6; bu = vb[7:0]; end
          4'hD: begin kind = 7; bu = vb[7:0]; end
          4'hF: kind = 8;
          default: kind = 0;
        endcase
      end
    endcase
    case (kind)
      1: begin
        t = ua + bu;
        r = 16'(t);
        c = (t > 65535);
        v = ((sa + bs) > 32767) || ((sa + bs) < -32768);
        upd = 1;
      end
      2, 3: begin
        r = (kind == 2) ? 16'(ua - bu) : 16'h0000;
        c = (ua < bu);
        l = c;
        n = (sa < bs);
        z = (ua == bu);
        v = ((sa - bs) > 32767) || ((sa - bs) < -32768);
        upd = 1;
      end
      4: begin r = 16'(ua & bu); z = (r == 16'h0000); upd = 1; end
      5: r = 16'(ua | bu);
      6: r = 16'(ua ^ bu);
      7: r = 16'(bu);
      8: r = {vb[7:0], 8'h00};
      9, 10: begin
        if (kind == 9) begin
          right = (bs < 0);
          m = right ? -bs : bs;
        end else begin
          right = op[0];
          m = vb[3:0];
        end
        if (m >= 16) r = (arith && right && va[15]) ? 16'hFFFF : 16'h0000;
        else if (!right) r = 16'(ua << m);
        else if (arith) r = 16'(sa >>> m);
        else r = 16'(ua >> m);
      end
      11: begin
        p = longint'(ua) * longint'(bu);
        r = 16'(p);
        c = ((p >> 16) != 0);
        z = (r == 16'h0000);
        upd = 1;
      end
      default: r = 16'h0000;
    endcase
    f = {c, l, v, z, n};
  endfunction

  // Scoreboard: compare the held output every cycle, pop on drain, push on accept.
  always @(negedge clk) begin
    logic [15:0] mr;
    logic [4:0]  mf;
    bit          mu;
    exp_t        e;
    if (!reset_n) begin
      exp_q.delete();
      psr_m = 5'h00;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", exp_q.size(), 1);
        end else begin
          e = exp_q[0];
          check("sb_result", result, e.r);
          check("sb_flags", flags, e.f);
          check("sb_psr", psr, e.p);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model(opcode, a, b, mr, mf, mu);
        if (mu) psr_m = mf;
        e.r = mr;
        e.f = mf;
        e.p = psr_m;
        exp_q.push_back(e);
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] va, input logic [15:0] vb);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    logic [7:0] ops [0:21];
    int         k, edges, n, sel;
    bit         bad;
    logic [7:0] op;
    logic [15:0] va, vb;

    ops = '{8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h84, 8'h86, 8'h80, 8'h81,
            8'h82, 8'h83, 8'h0E, 8'h50, 8'h90, 8'hB0, 8'h10, 8'h20, 8'h30, 8'hD0, 8'hF0};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    opcode   = 8'h00;
    a        = 16'h0000;
    b        = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_psr", psr, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h05, 16'h7FFF, 16'h0001);
    check("add_valid", out_valid, 1);
    check("add_result", result, 16'h8000);
    check("add_flags", flags, 5'h04);
    check("add_psr", psr, 5'h04);

    send(8'hB0, 16'h0005, 16'h00FF);
    check("cmpi_result", result, 16'h0000);
    check("cmpi_flags", flags, 5'h18);
    check("cmpi_psr", psr, 5'h18);

    send(8'h86, 16'h8000, 16'hFFFC);
    check("ashu_neg", result, 16'hF800);
    check("ashu_psr", psr, 5'h18);
    send(8'h84, 16'h8000, 16'hFFFC);
    check("lsh_neg", result, 16'h0800);
    send(8'h86, 16'h8000, 16'h0010);
    check("ashu_big", result, 16'h0000);
    check("shift_psr", psr, 5'h18);
    send(8'h86, 16'h8001, 16'h8000);
    check("ashu_minneg", result, 16'hFFFF);
    send(8'h83, 16'h8000, 16'h000F);
    check("ashui_right", result, 16'hFFFF);
    send(8'h07, 16'h1234, 16'h5678);
    check("unknown_result", result, 16'h0000);
    check("unknown_psr", psr, 5'h18);

    send(8'h0E, 16'h0100, 16'h0100);
    edges = 0;
    bad = 0;
    while (!out_valid && edges < 100) begin
      if (!busy || in_ready) bad = 1;
      @(posedge clk);
      #1;
      edges++;
    end
    check("mul_busy_window", bad, 0);
    check("mul_latency", edges, 17);
    check("mul_result", result, 16'h0000);
    check("mul_flags", flags, 5'h12);
    check("mul_psr", psr, 5'h12);
    check("mul_busy_done", busy, 0);

    repeat (2) @(posedge clk);
    #1;
    ready_force = 1'b0;
    send(8'h05, 16'hFFFF, 16'h0002);
    check("bp1_result", result, 16'h0001);
    check("bp1_psr", psr, 5'h10);
    opcode   = 8'h05;
    a        = 16'h7FFF;
    b        = 16'h0001;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) bad = 1;
    end
    check("bp_stall", bad, 0);
    check("bp_hold_result", result, 16'h0001);
    check("bp_hold_psr", psr, 5'h10);
    ready_force = 1'b1;
    wait_accept();
    check("bp2_result", result, 16'h8000);
    check("bp2_psr", psr, 5'h04);

    send(8'h0E, 16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_result", result, 0);
    check("mrst_flags", flags, 0);
    check("mrst_psr", psr, 0);
    check("mrst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 16'h00F0, 16'h0F00);
    check("and_result", result, 16'h0000);
    check("and_flags", flags, 5'h02);
    check("and_psr", psr, 5'h02);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      k = $urandom_range(0, 25);
      if (k > 21) op = 8'($urandom);
      else if (k >= 14) op = ops[k] | 8'($urandom_range(0, 15));
      else op = ops[k];
      va  = 16'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0: vb = 16'($urandom);
        1: vb = 16'($urandom_range(0, 20));
        2: vb = 16'(-int'($urandom_range(1, 20)));
        3: vb = va;
        default: vb = 16'h8000;
      endcase
      send(op, va, vb);
    end

    rand_ready  = 1'b0;
    ready_force = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
